reaction_test_ctrl: RTL and testbench

REACTION_TEST_CTRL -- requirements
Module: reaction_test_ctrl

---
 rtl/reaction_test_ctrl.sv | 217 +++++++++++++++++++++
 tb/tb_reaction_test_ctrl.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/reaction_test_ctrl.sv
// reaction_test_ctrl
// Reaction-time game controller. A session has ROUNDS trials. Each trial
// waits a random delay, lights the stimulus lamp, and then times the player's
// response in timebase ticks. Responses that come too early, too late, or
// during the wait phase fail the trial, and the same round is retried.
// When the last round is done, the session average is presented.
//
// Ports
//   clk             single clock
//   rst             asynchronous, active-high reset
//   i_tick          one-cycle timebase pulse (1 ms)
//   i_start         start button level
//   i_response      response button level
//   i_random_num    random delay in ticks, latched when a trial starts
//   o_state         current state code (IDLE=0 WAIT=1 TEST=2 DONE=3 FAIL=4 FINISH=5)
//   o_stim          stimulus lamp, high only in TEST
//   o_round         number of completed valid rounds
//   o_response_time last valid response time
//   o_best          fastest valid response this session (all ones when none)
//   o_avg           session average, non-zero only in FINISH
module reaction_test_ctrl #(
    parameter int TW     = 14,
    parameter int RW     = 13,
    parameter int ROUNDS = 4,
    parameter int MIN_RT = 100,
    parameter int MAX_RT = 9999
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_tick,
    input  logic          i_start,
    input  logic          i_response,
    input  logic [RW-1:0] i_random_num,
    output logic [2:0]    o_state,
    output logic          o_stim,
    output logic [4:0]    o_round,
    output logic [TW-1:0] o_response_time,
    output logic [TW-1:0] o_best,
    output logic [TW-1:0] o_avg
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WAIT   = 3'd1,
        ST_TEST   = 3'd2,
        ST_DONE   = 3'd3,
        ST_FAIL   = 3'd4,
        ST_FINISH = 3'd5
    } state_t;

    // The sum carries four extra bits so that up to 16 rounds cannot overflow.
    localparam int            SW       = TW + 4;
    localparam int            LOG_R    = $clog2(ROUNDS);
    localparam logic [TW-1:0] T_SAT    = {TW{1'b1}};
    localparam logic [TW-1:0] T_ONE    = TW'(1'b1);
    localparam logic [TW-1:0] MIN_T    = TW'(MIN_RT);
    localparam logic [TW-1:0] MAX_T    = TW'(MAX_RT);
    localparam logic [RW-1:0] D_ONE    = RW'(1'b1);
    localparam logic [4:0]    ROUNDS_R = 5'(ROUNDS);

    state_t        state_r, state_n_s;
    logic          start_q_r, resp_q_r;
    logic          start_edge_s, resp_edge_s;
    logic [TW-1:0] t_r, t_n_s;
    logic [RW-1:0] delay_r, delay_n_s, delay_latch_s;
    logic [4:0]    round_r, round_n_s;
    logic [TW-1:0] resp_r, resp_n_s;
    logic [TW-1:0] best_r, best_n_s;
    logic [SW-1:0] sum_r, sum_n_s;
    logic [TW-1:0] avg_r, avg_s;
    logic          stim_r;
    logic          delay_reached_s;

    // Only edges of the buttons matter; a held button never re-triggers.
    assign start_edge_s  = i_start & ~start_q_r;
    assign resp_edge_s   = i_response & ~resp_q_r;

    // A zero delay would skip the wait phase entirely, so it counts as one tick.
    assign delay_latch_s = (i_random_num == {RW{1'b0}}) ? D_ONE : i_random_num;

    // Both operands are zero-extended to a common width so TW and RW may differ.
    assign delay_reached_s = ({{RW{1'b0}}, t_r} >= {{TW{1'b0}}, delay_r});

    assign avg_s = TW'(sum_r >> LOG_R);

    assign o_state         = state_r;
    assign o_stim          = stim_r;
    assign o_round         = round_r;
    assign o_response_time = resp_r;
    assign o_best          = best_r;
    assign o_avg           = avg_r;

    // Next-state and next-value logic for the session controller.
    always_comb begin
        state_n_s = state_r;
        t_n_s     = t_r;
        delay_n_s = delay_r;
        round_n_s = round_r;
        resp_n_s  = resp_r;
        best_n_s  = best_r;
        sum_n_s   = sum_r;

        // The timer runs only while a trial is live and sticks at its maximum.
        if ((state_r == ST_WAIT || state_r == ST_TEST) && i_tick && (t_r != T_SAT)) begin
            t_n_s = t_r + T_ONE;
        end else begin
            t_n_s = t_r;
        end

        case (state_r)
            ST_IDLE: begin
                if (start_edge_s) begin
                    state_n_s = ST_WAIT;
                    delay_n_s = delay_latch_s;
                    t_n_s     = {TW{1'b0}};
                    round_n_s = 5'd0;
                    best_n_s  = T_SAT;
                    sum_n_s   = {SW{1'b0}};
                end else if (resp_edge_s) begin
                    state_n_s = ST_FAIL;
                end else begin
                    state_n_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (resp_edge_s) begin
                    state_n_s = ST_FAIL;
                end else if (delay_reached_s) begin
                    state_n_s = ST_TEST;
                    t_n_s     = {TW{1'b0}};
                end else begin
                    state_n_s = ST_WAIT;
                end
            end
            ST_TEST: begin
                // Decisions use the timer value before any coincident tick.
                if (t_r > MAX_T) begin
                    state_n_s = ST_FAIL;
                end else if (resp_edge_s) begin
                    if (t_r < MIN_T) begin
                        state_n_s = ST_FAIL;
                    end else begin
                        state_n_s = ST_DONE;
                        resp_n_s  = t_r;
                        best_n_s  = (t_r < best_r) ? t_r : best_r;
                        sum_n_s   = sum_r + {4'b0000, t_r};
                        round_n_s = round_r + 5'd1;
                    end
                end else begin
                    state_n_s = ST_TEST;
                end
            end
            ST_DONE: begin
                if (round_r == ROUNDS_R) begin
                    state_n_s = ST_FINISH;
                end else if (start_edge_s) begin
                    state_n_s = ST_WAIT;
                    delay_n_s = delay_latch_s;
                    t_n_s     = {TW{1'b0}};
                end else begin
                    state_n_s = ST_DONE;
                end
            end
            ST_FAIL: begin
                // Retry the same round; session results are kept.
                if (start_edge_s) begin
                    state_n_s = ST_WAIT;
                    delay_n_s = delay_latch_s;
                    t_n_s     = {TW{1'b0}};
                end else begin
                    state_n_s = ST_FAIL;
                end
            end
            ST_FINISH: begin
                if (start_edge_s) begin
                    state_n_s = ST_IDLE;
                end else begin
                    state_n_s = ST_FINISH;
                end
            end
            default: begin
                state_n_s = ST_IDLE;
            end
        endcase
    end

    // State, timer, session results and registered output decodes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            start_q_r <= 1'b0;
            resp_q_r  <= 1'b0;
            t_r       <= {TW{1'b0}};
            delay_r   <= {RW{1'b0}};
            round_r   <= 5'd0;
            resp_r    <= {TW{1'b0}};
            best_r    <= T_SAT;
            sum_r     <= {SW{1'b0}};
            avg_r     <= {TW{1'b0}};
            stim_r    <= 1'b0;
        end else begin
            state_r   <= state_n_s;
            start_q_r <= i_start;
            resp_q_r  <= i_response;
            t_r       <= t_n_s;
            delay_r   <= delay_n_s;
            round_r   <= round_n_s;
            resp_r    <= resp_n_s;
            best_r    <= best_n_s;
            sum_r     <= sum_n_s;
            // Decoded from the next state so the lamp and average line up with o_state.
            avg_r     <= (state_n_s == ST_FINISH) ? avg_s : {TW{1'b0}};
            stim_r    <= (state_n_s == ST_TEST);
        end
    end

endmodule

// File: tb/tb_reaction_test_ctrl.sv
module tb_reaction_test_ctrl;
    localparam int TW     = 14;
    localparam int RW     = 13;
    localparam int ROUNDS = 4;
    localparam int MIN_RT = 100;
    localparam int MAX_RT = 9999;
    localparam int ALL1   = (1 << TW) - 1;

    localparam int C_IDLE = 0, C_WAIT = 1, C_TEST = 2, C_DONE = 3, C_FAIL = 4, C_FINISH = 5;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          i_tick = 1'b0;
    logic          i_start = 1'b0;
    logic          i_response = 1'b0;
    logic [RW-1:0] i_random_num = '0;
    logic [2:0]    o_state;
    logic          o_stim;
    logic [4:0]    o_round;
    logic [TW-1:0] o_response_time, o_best, o_avg;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: list of valid times this session plus last valid time.
    int times_q[$];
    int m_rt = 0;

    reaction_test_ctrl #(.TW(TW), .RW(RW), .ROUNDS(ROUNDS), .MIN_RT(MIN_RT), .MAX_RT(MAX_RT)) dut (
        .clk(clk), .rst(rst), .i_tick(i_tick), .i_start(i_start), .i_response(i_response),
        .i_random_num(i_random_num), .o_state(o_state), .o_stim(o_stim), .o_round(o_round),
        .o_response_time(o_response_time), .o_best(o_best), .o_avg(o_avg)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int model_best();
        int b = ALL1;
        foreach (times_q[k]) if (times_q[k] < b) b = times_q[k];
        return b;
    endfunction

    function automatic int model_avg();
        int s = 0;
        foreach (times_q[k]) s += times_q[k];
        return s / ROUNDS;
    endfunction

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    // Deliver n tick pulses, sometimes separated by idle cycles.
    task automatic apply_ticks(input int n);
        for (int k = 0; k < n; k++) begin
            if ($urandom_range(0, 3) == 0) begin
                i_tick = 1'b0;
                cycle();
            end
            i_tick = 1'b1;
            cycle();
            i_tick = 1'b0;
        end
    endtask

    task automatic press_start(input int d, input bit with_resp);
        i_random_num = d[RW-1:0];
        i_start = 1'b1;
        if (with_resp) i_response = 1'b1;
        cycle();
        i_start = 1'b0;
        i_random_num = RW'($urandom);
        cycle();
    endtask

    task automatic check_results(input string tag);
        check({tag, "_round"}, o_round, times_q.size());
        check({tag, "_rt"}, o_response_time, m_rt);
        check({tag, "_best"}, o_best, model_best());
    endtask

    // One trial: d = delay, r = response tick (r > MAX_RT means no response),
    // w >= 0 = respond during wait at tick w, coinc = tick with the response,
    // hold = response button held down from the start press.
    task automatic run_trial(input int d, input int r, input int w, input bit coinc, input bit hold);
        int deff;
        deff = (d == 0) ? 1 : d;
        press_start(d, hold);
        check("wait_entry", o_state, C_WAIT);
        check("wait_stim", o_stim, 0);
        if (w >= 0) begin
            apply_ticks(w);
            i_response = 1'b1;
            cycle();
            i_response = 1'b0;
            check("wait_resp_state", o_state, C_FAIL);
            check_results("wait_resp");
            return;
        end
        apply_ticks(deff);
        check("wait_before_test", o_state, C_WAIT);
        cycle();
        check("test_entry", o_state, C_TEST);
        check("test_stim", o_stim, 1);
        apply_ticks((r > MAX_RT) ? MAX_RT + 1 : r);
        check("test_running", o_state, C_TEST);
        if (r > MAX_RT) begin
            cycle();
            check("timeout_state", o_state, C_FAIL);
            check("timeout_stim", o_stim, 0);
            check_results("timeout");
            return;
        end
        if (hold) begin
            i_response = 1'b0;
            cycle();
            check("hold_release", o_state, C_TEST);
        end
        i_response = 1'b1;
        i_tick = coinc;
        cycle();
        i_response = 1'b0;
        i_tick = 1'b0;
        if (r >= MIN_RT) begin
            times_q.push_back(r);
            m_rt = r;
            check("resp_state", o_state, C_DONE);
            check("resp_stim", o_stim, 0);
            check_results("resp");
            cycle();
            if (times_q.size() == ROUNDS) begin
                check("finish_state", o_state, C_FINISH);
                check("finish_avg", o_avg, model_avg());
                check("finish_best", o_best, model_best());
            end else begin
                check("done_state", o_state, C_DONE);
                check("done_avg", o_avg, 0);
            end
        end else begin
            check("early_state", o_state, C_FAIL);
            check_results("early");
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_state"}, o_state, C_IDLE);
        check({tag, "_stim"}, o_stim, 0);
        check({tag, "_round"}, o_round, 0);
        check({tag, "_rt"}, o_response_time, 0);
        check({tag, "_best"}, o_best, ALL1);
        check({tag, "_avg"}, o_avg, 0);
    endtask

    initial begin
        int guard;
        int kind;
        int d;

        // Reset values
        repeat (3) cycle();
        check_reset_outputs("reset");
        rst = 1'b0;
        cycle();
        check("idle_after_reset", o_state, C_IDLE);

        // Response alone in IDLE fails; reset brings it back
        i_response = 1'b1;
        cycle();
        i_response = 1'b0;
        check("idle_resp_fail", o_state, C_FAIL);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        cycle();
        check_reset_outputs("reset2");

        // Session 1: 200, 300 (button held from start, zero delay), 150 (coincident tick), 350
        run_trial(500, 200, -1, 1'b0, 1'b0);
        run_trial(0,   300, -1, 1'b0, 1'b1);
        run_trial(7,   150, -1, 1'b1, 1'b0);
        run_trial(20,  350, -1, 1'b0, 1'b0);
        check("s1_best", o_best, 150);
        check("s1_avg", o_avg, 250);

        // FINISH -> IDLE, average clears, other results hold
        press_start(0, 1'b0);
        check("finish_to_idle", o_state, C_IDLE);
        check("idle_avg_zero", o_avg, 0);
        check("idle_best_hold", o_best, model_best());

        // Session 2: boundaries, wait-phase response, timeout
        times_q.delete();
        run_trial(500, 250, -1, 1'b0, 1'b0);
        check("s2_rt250", o_response_time, 250);
        run_trial(50, 0, 10, 1'b0, 1'b0);
        run_trial(30, MIN_RT - 1, -1, 1'b0, 1'b0);
        run_trial(30, MIN_RT, -1, 1'b1, 1'b0);
        run_trial(5, MAX_RT + 1, -1, 1'b0, 1'b0);
        check("s2_round2", o_round, 2);

        // Reset asserted mid-TEST with two rounds done
        press_start(12, 1'b0);
        apply_ticks(12);
        cycle();
        check("pre_rst_test", o_state, C_TEST);
        apply_ticks(40);
        rst = 1'b1;
        #1;
        check_reset_outputs("async_rst");
        cycle();
        rst = 1'b0;
        cycle();
        times_q.delete();
        m_rt = 0;
        check_reset_outputs("after_rst");

        // Session 3: randomized trials until the session finishes
        guard = 0;
        while (times_q.size() < ROUNDS && guard < 40) begin
            guard++;
            kind = $urandom_range(0, 5);
            d = $urandom_range(0, 60);
            if (kind == 0) begin
                d = $urandom_range(20, 60);
                run_trial(d, 0, $urandom_range(0, d - 1), 1'b0, 1'b0);
            end else if (kind == 1) begin
                run_trial(d, $urandom_range(0, MIN_RT - 1), -1, 1'($urandom_range(0, 1)), 1'b0);
            end else begin
                run_trial(d, $urandom_range(MIN_RT, MIN_RT + 400), -1,
                          1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0));
            end
        end
        check("s3_finished", o_state, C_FINISH);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
